nms_window_reader: RTL and testbench

Reader-side block for the three-row line-buffer taps in the Canny non-maximum-suppression (NMS) stage. It consumes one column of three vertically aligned 20-bit gradient-magnitude samples plus a 2-bit gradient angle per beat. From these it assembles a 3x3 window, tracks raster position, and applies directional non-maximum suppression. It emits one thinned magnitude per interior pixel to the hysteresis stage.

---
 rtl/canny_pkg.sv | 21 ++
 rtl/nms_window_reader_if.sv | 24 ++
 rtl/nms_cmp.sv | 38 +++
 rtl/nms_window_reader.sv | 84 ++++++++
 tb/tb_nms_window_reader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny NMS stage: magnitude width, angle codes and
// default frame geometry, shared with the line buffer.
package canny_pkg;

  localparam int DW     = 20;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;

  typedef enum logic [1:0] {
    ANG_H   = 2'd0,
    ANG_45  = 2'd1,
    ANG_V   = 2'd2,
    ANG_135 = 2'd3
  } ang_t;

  // Counter width that still works for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nms_window_reader_if.sv
// Column-tap input and thinned-magnitude output of the NMS window reader.
interface nms_window_reader_if #(
  parameter int DW = canny_pkg::DW
);
  logic          in_valid;
  logic [DW-1:0] row0;
  logic [DW-1:0] row1;
  logic [DW-1:0] row2;
  logic [1:0]    ang_in;
  logic          out_valid;
  logic [DW-1:0] out_mag;
  logic          out_eol;
  logic          out_eof;

  modport master (
    output in_valid, row0, row1, row2, ang_in,
    input  out_valid, out_mag, out_eol, out_eof
  );

  modport slave (
    input  in_valid, row0, row1, row2, ang_in,
    output out_valid, out_mag, out_eol, out_eof
  );
endinterface

// File: rtl/nms_cmp.sv
// Directional non-maximum suppression on a 3x3 window (win[row][col], row 0 top,
// col 0 left). NMS_LOW_THRESH_EN adds a floor: centres below LOW_THR output 0.
module nms_cmp import canny_pkg::*; #(
  parameter int          DW      = canny_pkg::DW,
  parameter logic [DW-1:0] LOW_THR = '0
) (
  input  logic [2:0][2:0][DW-1:0] win,
  input  ang_t                    ang,
  output logic [DW-1:0]           mag
);

  logic [DW-1:0] c, a, b;
  logic          keep;

  always_comb begin
    c = win[1][1];
    a = win[1][0];
    b = win[1][2];
    case (ang)
      ANG_45:  begin a = win[0][2]; b = win[2][0]; end
      ANG_V:   begin a = win[0][1]; b = win[2][1]; end
      ANG_135: begin a = win[0][0]; b = win[2][2]; end
      default: ;
    endcase
    // Ties keep the centre so flat ridges are not erased.
    keep = (c >= a) && (c >= b);
`ifdef NMS_LOW_THRESH_EN
    keep = keep && (c >= LOW_THR);
`endif
    mag = keep ? c : '0;
  end

`ifndef NMS_LOW_THRESH_EN
  logic unused_thr;
  assign unused_thr = ^LOW_THR;
`endif

endmodule

// File: rtl/nms_window_reader.sv
// NMS reader: builds a 3x3 window from line-buffer column taps, tracks raster
// position and emits one thinned magnitude per interior pixel (NMS_LOW_THRESH_EN via nms_cmp).
module nms_window_reader import canny_pkg::*; #(
  parameter int            WIDTH   = canny_pkg::WIDTH,
  parameter int            HEIGHT  = canny_pkg::HEIGHT,
  parameter int            DW      = canny_pkg::DW,
  parameter logic [DW-1:0] LOW_THR = '0
) (
  input logic                clk,
  input logic                rst,
  nms_window_reader_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam int RW = cnt_w(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [2:0][2:0][DW-1:0] win;
  ang_t                    ang_q, ang_c;
  logic [1:0]              vld_pipe, eol_pipe, eof_pipe;
  logic [DW-1:0]           mag_d, mag_q;
  logic                    col_end, row_end, emit;

  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);
  // Position is judged before the counters advance; cols 0-1 never emit, so
  // window columns straddling a row wrap are never consumed.
  assign emit    = bus.in_valid && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      win   <= '0;
      ang_q <= ANG_H;
      ang_c <= ANG_H;
    end else if (bus.in_valid) begin
      win[0] <= {bus.row0, win[0][2], win[0][1]};
      win[1] <= {bus.row1, win[1][2], win[1][1]};
      win[2] <= {bus.row2, win[2][2], win[2][1]};
      // Two-deep so ang_c follows the centre column, not the newest one.
      ang_q  <= ang_t'(bus.ang_in);
      ang_c  <= ang_q;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  nms_cmp #(
    .DW      (DW),
    .LOW_THR (LOW_THR)
  ) u_cmp (
    .win (win),
    .ang (ang_c),
    .mag (mag_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      eol_pipe <= '0;
      eof_pipe <= '0;
      mag_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], emit};
      eol_pipe <= {eol_pipe[0], emit && col_end};
      eof_pipe <= {eof_pipe[0], emit && col_end && row_end};
      if (vld_pipe[0]) mag_q <= mag_d;
    end
  end

  assign bus.out_valid = vld_pipe[1];
  assign bus.out_eol   = eol_pipe[1];
  assign bus.out_eof   = eof_pipe[1];
  assign bus.out_mag   = mag_q;

endmodule

// File: tb/tb_nms_window_reader.sv
// Randomized frame bench for nms_window_reader: streams images as column taps
// and compares every emitted pixel with an image-coordinate NMS reference.
module tb_nms_window_reader;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int D   = 20;
  localparam int THR = 30;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nms_window_reader_if #(.DW(D)) bus ();

  nms_window_reader #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .DW      (D),
    .LOW_THR (D'(THR))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [D-1:0] img  [H][W];
  logic [1:0]   angs [H][W];
  logic [D-1:0] q_mag[$];
  logic [D-1:0] ref_mag[$];
  bit           q_eol[$];
  bit           q_eof[$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q_mag.push_back(bus.out_mag);
      q_eol.push_back(bus.out_eol);
      q_eof.push_back(bus.out_eof);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [D-1:0] rnd_mag();
    if ($urandom_range(0, 7) == 0) return D'($urandom);
    return D'($urandom_range(0, 63));
  endfunction

  // Reference NMS for pixel (pr,pc) taken straight from the image.
  function automatic logic [D-1:0] nms_ref(input int pr, input int pc);
    logic [D-1:0] cv, av, bv;
    bit ok;
    cv = img[pr][pc];
    case (angs[pr][pc])
      2'd0:    begin av = img[pr][pc-1];   bv = img[pr][pc+1];   end
      2'd1:    begin av = img[pr-1][pc+1]; bv = img[pr+1][pc-1]; end
      2'd2:    begin av = img[pr-1][pc];   bv = img[pr+1][pc];   end
      default: begin av = img[pr-1][pc-1]; bv = img[pr+1][pc+1]; end
    endcase
    ok = (cv >= av) && (cv >= bv);
`ifdef NMS_LOW_THRESH_EN
    ok = ok && (cv >= D'(THR));
`endif
    return ok ? cv : '0;
  endfunction

  function automatic logic [D-1:0] tap(input int r, input int c);
    if (r < 0) return rnd_mag();
    return img[r][c];
  endfunction

  task automatic fill_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c]  = rnd_mag();
        angs[r][c] = 2'($urandom_range(0, 3));
      end
  endtask

  // Streams the image; abort_at >= 0 pulses rst between edges after that beat.
  task automatic run_frame(input int gap_pct, input bit probe, input int abort_at);
    q_mag.delete(); q_eol.delete(); q_eof.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; g++) begin
          bus.in_valid = 1'b0;
          bus.row0 = rnd_mag(); bus.row1 = rnd_mag(); bus.row2 = rnd_mag();
          bus.ang_in = 2'($urandom);
          @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.row0   = tap(r - 2, c);
        bus.row1   = tap(r - 1, c);
        bus.row2   = tap(r, c);
        bus.ang_in = (r >= 1) ? angs[r-1][c] : 2'($urandom);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (probe && r == 2 && c == 2) begin
          chk("lat0", 32'(bus.out_valid), 0);
          @(posedge clk); #1;
          chk("lat1", 32'(bus.out_valid), 1);
          chk("lat_mag", 32'(bus.out_mag), 32'(nms_ref(1, 1)));
          @(posedge clk); #1;
          chk("pulse", 32'(bus.out_valid), 0);
          chk("hold", 32'(bus.out_mag), 32'(nms_ref(1, 1)));
        end
        if (r * W + c == abort_at) begin
          #2 rst = 1'b1;
          #1;
          chk("arst_valid", 32'(bus.out_valid), 0);
          chk("arst_mag", 32'(bus.out_mag), 0);
          chk("arst_eol", 32'(bus.out_eol), 0);
          chk("arst_eof", 32'(bus.out_eof), 0);
          #1 rst = 1'b0;
          return;
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame();
    int n_eol, n_eof;
    n_eol = 0; n_eof = 0;
    chk("count", q_mag.size(), NOUT);
    for (int i = 0; i < q_mag.size() && i < NOUT; i++) begin
      int pr, pc;
      pr = i / (W - 2) + 1;
      pc = i % (W - 2) + 1;
      chk("mag", 32'(q_mag[i]), 32'(nms_ref(pr, pc)));
      chk("eol", 32'(q_eol[i]), 32'(pc == W - 2));
      chk("eof", 32'(q_eof[i]), 32'(pc == W - 2 && pr == H - 2));
    end
    foreach (q_eol[i]) n_eol += int'(q_eol[i]);
    foreach (q_eof[i]) n_eof += int'(q_eof[i]);
    chk("eol_cnt", n_eol, H - 2);
    chk("eof_cnt", n_eof, 1);
  endtask

  // Centre pixel (2,2) is the 8th output of a frame.
  task automatic directed(input string tag, input logic [D-1:0] exp);
    run_frame(0, 0, -1);
    check_frame();
    if (q_mag.size() > 7) chk(tag, 32'(q_mag[7]), 32'(exp));
    else                  chk(tag, 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.row0 = '0; bus.row1 = '0; bus.row2 = '0; bus.ang_in = '0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_mag", 32'(bus.out_mag), 0);
    chk("rst_eol", 32'(bus.out_eol), 0);
    chk("rst_eof", 32'(bus.out_eof), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_img();
    run_frame(0, 1, -1);
    check_frame();
    ref_mag = q_mag;

    run_frame(40, 0, -1);
    check_frame();
    chk("gap_n", q_mag.size(), ref_mag.size());
    for (int i = 0; i < q_mag.size() && i < ref_mag.size(); i++)
      chk("gap_eq", 32'(q_mag[i]), 32'(ref_mag[i]));

    fill_img();
    img[2][2] = 100; img[2][1] = 50; img[2][3] = 60; angs[2][2] = 2'd0;
    directed("h_max", 100);

    fill_img();
    img[2][2] = 50; img[2][1] = 10; img[2][3] = 100; angs[2][2] = 2'd0;
    directed("h_sup", 0);

    fill_img();
    img[2][2] = 150; img[1][3] = 200; img[3][1] = 10; angs[2][2] = 2'd1;
    directed("d45_sup", 0);
    img[1][1] = 10; img[3][3] = 10; angs[2][2] = 2'd3;
    directed("d135_max", 150);

    fill_img();
    img[2][2] = 80; img[1][2] = 80; img[3][2] = 80; angs[2][2] = 2'd2;
    directed("v_tie", 80);

    fill_img();
    img[2][2] = 29; img[2][1] = 5; img[2][3] = 5; angs[2][2] = 2'd0;
`ifdef NMS_LOW_THRESH_EN
    directed("thr29", 0);
`else
    directed("thr29", 29);
`endif
    img[2][2] = 30;
    directed("thr30", 30);

    fill_img();
    run_frame(20, 0, 3 * W + 4);
    fill_img();
    run_frame(20, 0, -1);
    check_frame();

    repeat (3) begin
      fill_img();
      run_frame(30, 0, -1);
      check_frame();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
